// File: rtl/h80bus_pkg.sv
//============================================================================
// Module   : h80bus_pkg
// Purpose  : Shared h80 bus command encodings and arbiter owner type.
// Revision : 1.0
//============================================================================
`default_nettype none

package h80bus_pkg;

    // Bit 0 of a command selects read (1) or write (0).
    localparam logic [2:0] BUS_CMD_WRITE   = 3'b000;
    localparam logic [2:0] BUS_CMD_READ    = 3'b001;
    localparam logic [2:0] BUS_CMD_WRITE_W = 3'b010;
    localparam logic [2:0] BUS_CMD_READ_W  = 3'b011;
    localparam logic [2:0] BUS_CMD_WRITE_B = 3'b100;
    localparam logic [2:0] BUS_CMD_READ_B  = 3'b101;

    typedef enum logic [0:0] {
        OWN0 = 1'b0,
        OWN1 = 1'b1
    } arb_owner_t;

endpackage

`default_nettype wire

// File: rtl/h80bus_sat_counter.sv
//============================================================================
// Module   : h80bus_sat_counter
// Purpose  : Saturating up-counter with synchronous clear (clear wins).
// Revision : 1.0
//============================================================================
`default_nettype none

module h80bus_sat_counter #(
    parameter int LIMIT = 8,
    parameter int WIDTH = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] C_LIMIT = WIDTH'(LIMIT);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count < C_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/h80bus_arbiter.sv
//============================================================================
// Module   : h80bus_arbiter
// Purpose  : Two-master h80 bus arbiter, master 0 priority with starvation
//            guard for master 1. Optional bus lock: H80_ARB_LOCK_EN.
// Revision : 1.0
//============================================================================
`default_nettype none

module h80bus_arbiter
    import h80bus_pkg::*;
#(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3,
    parameter int BUS_DATA_WIDTH = 16,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef H80_ARB_LOCK_EN
    input  logic                      m0_lock,
    input  logic                      m1_lock,
`endif
    input  logic                      m0_ce_n,
    input  logic [BUS_ADDR_WIDTH-1:0] m0_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  m0_cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] m0_data_,
    output logic                      m0_wait_n,
    input  logic                      m1_ce_n,
    input  logic [BUS_ADDR_WIDTH-1:0] m1_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  m1_cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] m1_data_,
    output logic                      m1_wait_n,
    output logic                      s_ce_n,
    output logic [BUS_ADDR_WIDTH-1:0] s_addr,
    output logic [BUS_CMD_WIDTH-1:0]  s_cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] s_data_,
    input  logic                      s_wait_n,
    output logic                      owner
);

    localparam int C_CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_owner_t                r_owner;
    arb_owner_t                w_next;
    logic [C_CNT_W-1:0]        w_starve_cnt;
    logic                      w_own_ce_n;
    logic [BUS_ADDR_WIDTH-1:0] w_own_addr;
    logic [BUS_CMD_WIDTH-1:0]  w_own_cmd;
    logic                      w_own_lock;
    logic                      w_switch_pt;
    logic                      w_starved;
    logic                      w_wr_en;
    logic                      w_rd_en;

    assign w_own_ce_n = (r_owner == OWN1) ? m1_ce_n : m0_ce_n;
    assign w_own_addr = (r_owner == OWN1) ? m1_addr : m0_addr;
    assign w_own_cmd  = (r_owner == OWN1) ? m1_cmd  : m0_cmd;

`ifdef H80_ARB_LOCK_EN
    assign w_own_lock = (r_owner == OWN1) ? m1_lock : m0_lock;
`else
    assign w_own_lock = 1'b0;
`endif

    // An idle owner is always a switch point, so a held lock dies with idle.
    assign w_switch_pt = w_own_ce_n | (s_wait_n & ~w_own_lock);
    assign w_starved   = (w_starve_cnt >= C_CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= OWN0;
        end else begin
            r_owner <= w_next;
        end
    end

    always_comb begin
        w_next    = r_owner;
        s_ce_n    = 1'b1;
        s_addr    = w_own_addr;
        s_cmd     = w_own_cmd;
        m0_wait_n = 1'b0;
        m1_wait_n = 1'b0;
        case (r_owner)
            OWN0: if (w_switch_pt && !m1_ce_n && (m0_ce_n || w_starved)) w_next = OWN1;
            OWN1: if (w_switch_pt && !m0_ce_n) w_next = OWN0;
            default: w_next = OWN0;
        endcase
        if (!reset) begin
            s_ce_n    = w_own_ce_n;
            m0_wait_n = (r_owner == OWN0) ? s_wait_n : m0_ce_n;
            m1_wait_n = (r_owner == OWN1) ? s_wait_n : m1_ce_n;
        end
    end

    h80bus_sat_counter #(
        .LIMIT (STARVE_LIMIT),
        .WIDTH (C_CNT_W)
    ) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   ((r_owner == OWN0) && (w_next == OWN1)),
        .inc   ((r_owner == OWN0) && !m1_ce_n && !w_own_lock),
        .count (w_starve_cnt)
    );

    assign w_wr_en = !reset && !w_own_ce_n && (w_own_cmd[0] == BUS_CMD_WRITE[0]);
    assign w_rd_en = !reset && !w_own_ce_n && (w_own_cmd[0] == BUS_CMD_READ[0]);

    assign s_data_  = w_wr_en ? ((r_owner == OWN1) ? m1_data_ : m0_data_) : 'z;
    assign m0_data_ = (w_rd_en && (r_owner == OWN0)) ? s_data_ : 'z;
    assign m1_data_ = (w_rd_en && (r_owner == OWN1)) ? s_data_ : 'z;

    assign owner = (r_owner == OWN1);

endmodule

`default_nettype wire

// File: tb/tb_h80bus_arbiter.sv
//============================================================================
// Module   : tb_h80bus_arbiter
// Purpose  : Directed vector bench for h80bus_arbiter with a memory slave.
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_h80bus_arbiter;
    import h80bus_pkg::*;

    logic        clk;
    logic        reset;
    logic        m0_ce_n, m1_ce_n;
    logic [15:0] m0_addr, m1_addr;
    logic [2:0]  m0_cmd, m1_cmd;
    logic [15:0] m0_dout, m1_dout;
    wire  [15:0] m0_data_, m1_data_, s_data_;
    logic        m0_wait_n, m1_wait_n;
    logic        s_ce_n;
    logic [15:0] s_addr;
    logic [2:0]  s_cmd;
    logic        s_wait_n;
    logic        owner;
    logic        mem_clr;
    logic [15:0] mem [0:255];
`ifdef H80_ARB_LOCK_EN
    logic        m0_lock, m1_lock;
`endif

    int nvec  = 0;
    int nfail = 0;

    h80bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
`ifdef H80_ARB_LOCK_EN
        .m0_lock   (m0_lock),
        .m1_lock   (m1_lock),
`endif
        .m0_ce_n   (m0_ce_n),
        .m0_addr   (m0_addr),
        .m0_cmd    (m0_cmd),
        .m0_data_  (m0_data_),
        .m0_wait_n (m0_wait_n),
        .m1_ce_n   (m1_ce_n),
        .m1_addr   (m1_addr),
        .m1_cmd    (m1_cmd),
        .m1_data_  (m1_data_),
        .m1_wait_n (m1_wait_n),
        .s_ce_n    (s_ce_n),
        .s_addr    (s_addr),
        .s_cmd     (s_cmd),
        .s_data_   (s_data_),
        .s_wait_n  (s_wait_n),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Masters drive write data; memory slave drives read data.
    assign m0_data_ = (!m0_ce_n && !m0_cmd[0]) ? m0_dout : 'z;
    assign m1_data_ = (!m1_ce_n && !m1_cmd[0]) ? m1_dout : 'z;
    assign s_data_  = (!s_ce_n && s_cmd[0]) ? mem[s_addr[8:1]] : 'z;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (!s_ce_n && s_wait_n && !s_cmd[0]) begin
            if (s_cmd == BUS_CMD_WRITE_B) begin
                if (s_addr[0]) mem[s_addr[8:1]][15:8] <= s_data_[15:8];
                else           mem[s_addr[8:1]][7:0]  <= s_data_[7:0];
            end else begin
                mem[s_addr[8:1]] <= s_data_;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_ce_n = 1'b1; m1_ce_n = 1'b1;
        m0_cmd = BUS_CMD_READ_W; m1_cmd = BUS_CMD_READ_W;
        m0_addr = 16'h0100; m1_addr = 16'h0201;
        m0_dout = 16'h0000; m1_dout = 16'h0000;
        s_wait_n = 1'b1;
`ifdef H80_ARB_LOCK_EN
        m0_lock = 1'b0; m1_lock = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        m0_ce_n;
        logic        m1_ce_n;
        logic        s_wait;
        logic        e_owner;
        logic        e_s_ce_n;
        logic        e_m0w;
        logic        e_m1w;
        logic [15:0] e_addr;
    } vec_t;

    vec_t vecs [10];
    int   first_grant, second_grant;
    logic own_after;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0201};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0201};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0201};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000};

        idle_inputs();
        reset   = 1'b1;
        mem_clr = 1'b1;
        @(negedge clk);
        // Reset state with master 0 requesting: slave stays deselected.
        m0_ce_n = 1'b0;
        #2;
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_s_ce_n", 32'(s_ce_n), 32'd1);
        chk("rst_m0_wait_n", 32'(m0_wait_n), 32'd0);
        chk("rst_m1_wait_n", 32'(m1_wait_n), 32'd0);
        @(negedge clk);
        mem_clr = 1'b0;
        do_reset();

        // Table: arbitration and wait routing, all reads.
        for (int i = 0; i < 10; i++) begin
            m0_ce_n  = vecs[i].m0_ce_n;
            m1_ce_n  = vecs[i].m1_ce_n;
            s_wait_n = vecs[i].s_wait;
            #2;
            chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].e_owner));
            chk($sformatf("vec%0d_s_ce_n", i), 32'(s_ce_n), 32'(vecs[i].e_s_ce_n));
            chk($sformatf("vec%0d_m0_wait_n", i), 32'(m0_wait_n), 32'(vecs[i].e_m0w));
            chk($sformatf("vec%0d_m1_wait_n", i), 32'(m1_wait_n), 32'(vecs[i].e_m1w));
            if (!vecs[i].e_s_ce_n)
                chk($sformatf("vec%0d_s_addr", i), 32'(s_addr), 32'(vecs[i].e_addr));
            @(negedge clk);
        end

        // Master 0 alone: writes then reads back.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            m0_ce_n = 1'b0;
            m0_cmd  = (i < 4) ? BUS_CMD_WRITE_W : BUS_CMD_READ_W;
            m0_addr = 16'h0100 + 16'(2 * (i % 4));
            m0_dout = 16'h1234 + 16'(i % 4);
            #2;
            chk("m0only_owner", 32'(owner), 32'd0);
            chk("m0only_m0_wait_n", 32'(m0_wait_n), 32'd1);
            if (i >= 4)
                chk("m0only_rdata", 32'(m0_data_), 32'(16'h1234 + 16'(i % 4)));
            @(negedge clk);
        end

        // Slave stall during master-0 read with master 1 waiting.
        do_reset();
        m0_ce_n = 1'b0; m0_cmd = BUS_CMD_READ_W; m0_addr = 16'h0100;
        m1_ce_n = 1'b0; m1_cmd = BUS_CMD_READ_W;
        s_wait_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_owner", 32'(owner), 32'd0);
            chk("stall_m0_wait_n", 32'(m0_wait_n), 32'd0);
            @(negedge clk);
        end
        s_wait_n = 1'b1;
        #2;
        chk("stall_done_owner", 32'(owner), 32'd0);
        chk("stall_m0_rdata", 32'(m0_data_), 32'h1234);
        chk("stall_s_data", 32'(s_data_), 32'h1234);
        @(negedge clk);
        m0_ce_n = 1'b1;
        #2;
        chk("stall_idle_owner", 32'(owner), 32'd0);
        @(negedge clk);
        #2;
        chk("stall_grant_owner", 32'(owner), 32'd1);
        @(negedge clk);

        // Starvation: master 0 reads back-to-back, master 1 keeps requesting.
        do_reset();
        m0_ce_n = 1'b0; m0_cmd = BUS_CMD_READ_W;
        m1_ce_n = 1'b0; m1_cmd = BUS_CMD_READ_W;
        first_grant = -1; second_grant = -1; own_after = 1'b1;
        for (int c = 0; c < 30; c++) begin
            #2;
            if (first_grant >= 0 && c == first_grant + 1) own_after = owner;
            if (owner && first_grant < 0) first_grant = c;
            else if (owner && first_grant >= 0 && second_grant < 0 && c > first_grant + 1)
                second_grant = c;
            @(negedge clk);
        end
        chk("starve_first_grant", 32'(first_grant), 32'd9);
        chk("starve_regrant_m0", 32'(own_after), 32'd0);
        chk("starve_second_grant", 32'(second_grant), 32'd19);

        // Master 1 alone from reset: byte write to odd address.
        reset = 1'b1; mem_clr = 1'b1;
        idle_inputs();
        @(negedge clk);
        mem_clr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m1_ce_n = 1'b0; m1_cmd = BUS_CMD_WRITE_B; m1_addr = 16'h0201; m1_dout = 16'hA5A5;
        #2;
        chk("m1first_c0_owner", 32'(owner), 32'd0);
        chk("m1first_c0_wait_n", 32'(m1_wait_n), 32'd0);
        chk("m1first_c0_s_ce_n", 32'(s_ce_n), 32'd1);
        @(negedge clk);
        #2;
        chk("m1first_c1_owner", 32'(owner), 32'd1);
        chk("m1first_c1_wait_n", 32'(m1_wait_n), 32'd1);
        chk("m1first_c1_s_addr", 32'(s_addr), 32'h0201);
        @(negedge clk);
        m1_ce_n = 1'b1;
        #2;
        chk("m1first_mem", 32'(mem[0]), 32'hA500);

        // Reset mid-transfer: stalled master-1 word write is aborted.
        @(negedge clk);
        m1_ce_n = 1'b0; m1_cmd = BUS_CMD_WRITE_W; m1_dout = 16'h5A5A; s_wait_n = 1'b0;
        #2;
        chk("rstmid_owner_pre", 32'(owner), 32'd1);
        chk("rstmid_s_ce_n_pre", 32'(s_ce_n), 32'd0);
        reset = 1'b1;
        #1;
        chk("rstmid_owner", 32'(owner), 32'd0);
        chk("rstmid_s_ce_n", 32'(s_ce_n), 32'd1);
        chk("rstmid_m1_wait_n", 32'(m1_wait_n), 32'd0);
        nvec++;
        if (s_data_ !== 16'hzzzz) begin
            nfail++;
            $display("FAIL rstmid_s_data: got %h expected zzzz", s_data_);
        end
        @(negedge clk);
        m1_ce_n = 1'b1; s_wait_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("rstmid_mem", 32'(mem[0]), 32'hA500);
        @(negedge clk);

`ifdef H80_ARB_LOCK_EN
        // Locked read-modify-write by master 1 while master 0 requests.
        do_reset();
        m1_ce_n = 1'b0; m1_cmd = BUS_CMD_READ_W; m1_lock = 1'b1;
        #2;
        chk("lock_c0_owner", 32'(owner), 32'd0);
        @(negedge clk);
        m0_ce_n = 1'b0;
        #2;
        chk("lock_rd_owner", 32'(owner), 32'd1);
        @(negedge clk);
        m1_cmd = BUS_CMD_WRITE_W; m1_dout = 16'h0F0F;
        #2;
        chk("lock_wr_owner", 32'(owner), 32'd1);
        chk("lock_wr_m0_wait_n", 32'(m0_wait_n), 32'd0);
        @(negedge clk);
        m1_ce_n = 1'b1;
        #2;
        chk("lock_idle_owner", 32'(owner), 32'd1);
        @(negedge clk);
        #2;
        chk("lock_release_owner", 32'(owner), 32'd0);
        chk("lock_release_m0_wait_n", 32'(m0_wait_n), 32'd1);
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
